// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding and
// parameter defaults/limits.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_NEXT,
        ST_DESEL
    } spi_mst_state_t;

    localparam int SPI_DATA_W_DEF  = 8;
    localparam int SPI_CLK_DIV_MIN = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider. While enabled, toggles sclk every CLK_DIV cycles;
// rise/fall strobes are high in the cycle before the edge they announce.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_rise_stb,
    output logic o_fall_stb,
    output logic o_sclk
);

    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_wrap;

    assign w_wrap = i_en && (r_cnt == CNT_MAX);

    // Disabled means parked: counter cleared and sclk low, ready for a fresh start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_rise_stb = w_wrap && !r_sclk;
    assign o_fall_stb = w_wrap &&  r_sclk;
    assign o_sclk     = r_sclk;

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first, valid/ready byte interface.
// Optional feature macro SPI_MASTER_LOOPBACK_EN adds a 'loopback' input (rx samples mosi).
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              cs_hold,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
`ifdef SPI_MASTER_LOOPBACK_EN
    , input logic             loopback
`endif
);

    localparam int               DIV      = (CLK_DIV < SPI_CLK_DIV_MIN) ? SPI_CLK_DIV_MIN : CLK_DIV;
    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_mst_state_t    r_state;
    logic [DATA_W-2:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_rx_data;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_dcnt;
    logic              r_hold;
    logic              r_desel_hi;
    logic              r_rx_valid;
    logic              r_tx_ready;
    logic              r_busy;
    logic              r_cs;
    logic              r_mosi;

    logic w_accept;
    logic w_sclk_en;
    logic w_rise;
    logic w_fall;
    logic w_sdi;

    assign w_accept  = tx_valid && r_tx_ready;
    // SETUP is the first low half-period, so the divider wraps into bit 0's rising edge.
    assign w_sclk_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_sdi = loopback ? r_mosi : miso;
`else
    assign w_sdi = miso;
`endif

    spi_sclk_gen #(
        .CLK_DIV (DIV)
    ) u_sclk_gen (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_en       (w_sclk_en),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall),
        .o_sclk     (sclk)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_dcnt     <= '0;
            r_hold     <= 1'b0;
            r_desel_hi <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rise) begin
                r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_sdi};
            end
            case (r_state)
                ST_IDLE, ST_NEXT: begin
                    if (w_accept) begin
                        r_tx_sr    <= tx_data[DATA_W-2:0];
                        r_mosi     <= tx_data[DATA_W-1];
                        r_hold     <= cs_hold;
                        r_bit_cnt  <= '0;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_state    <= (r_state == ST_IDLE) ? ST_SETUP : ST_SHIFT;
                    end
                end
                ST_SETUP: begin
                    if (w_rise) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_rx_data  <= r_rx_sr;
                            r_rx_valid <= 1'b1;
                            if (r_hold) begin
                                r_tx_ready <= 1'b1;
                                r_state    <= ST_NEXT;
                            end else begin
                                r_dcnt     <= '0;
                                r_desel_hi <= 1'b0;
                                r_state    <= ST_DESEL;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_mosi    <= r_tx_sr[DATA_W-2];
                            r_tx_sr   <= r_tx_sr << 1;
                        end
                    end
                end
                // First DIV cycles hold cs low after the last falling edge, next DIV cycles drive it high.
                ST_DESEL: begin
                    if (r_dcnt == CNT_MAX) begin
                        r_dcnt <= '0;
                        if (!r_desel_hi) begin
                            r_desel_hi <= 1'b1;
                            r_cs       <= 1'b1;
                        end else begin
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign cs       = r_cs;
    assign mosi     = r_mosi;

endmodule
